// File: rtl/branch_resolver.sv
// Requester side of a 2-bit branch predictor interface.
// It issues predictor requests for fetched branches. It captures each prediction one cycle
// later into an in-order in-flight queue. When execute resolves the oldest branch, it drives
// result/taken back to the predictor and flags mispredicts, which flush the wrong-path entries.
module branch_resolver #(
  parameter int DEPTH  = 4,
  parameter int STAT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  output logic                       request,
  input  logic                       prediction,
  output logic                       pred_valid,
  output logic                       pred_taken,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  output logic                       result,
  output logic                       taken,
  output logic                       mispredict,
  output logic                       resolve_err,
  output logic [$clog2(DEPTH+1)-1:0] inflight,
  output logic [STAT_W-1:0]          stat_branches,
  output logic [STAT_W-1:0]          stat_mispreds
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] pred_q;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             pending;
  logic             mis_now;
  logic             pop;
  logic             push;

  // Pending capture counts against capacity so a full queue never overflows on capture.
  assign inflight    = count + CW'(pending);
  assign pop         = resolve_valid && (count != '0);
  assign mis_now     = pop && (pred_q[head] != resolve_taken);
  assign push        = pending && !mis_now;
  assign fetch_ready = (inflight < CW'(DEPTH)) && !mis_now;
  assign request     = fetch_valid && fetch_ready;

  // Queue, pending capture stage and pointers; a mispredict discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_q  <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else if (mis_now) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      pending <= request;
      if (push) begin
        pred_q[tail] <= prediction;
        tail         <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Registered one-cycle pulses toward fetch and the predictor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      result      <= 1'b0;
      taken       <= 1'b0;
      mispredict  <= 1'b0;
      resolve_err <= 1'b0;
    end else begin
      pred_valid  <= push;
      pred_taken  <= push && prediction;
      result      <= pop;
      taken       <= pop && resolve_taken;
      mispredict  <= mis_now;
      resolve_err <= resolve_valid && (count == '0);
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispreds <= '0;
    end else begin
      if (pop && (stat_branches != '1)) stat_branches <= stat_branches + STAT_W'(1);
      if (mis_now && (stat_mispreds != '1)) stat_mispreds <= stat_mispreds + STAT_W'(1);
    end
  end

endmodule
